ctrl_sequencer: RTL and testbench
=================================

Name: ctrl_sequencer

Overview:
- Hardwired control unit for the bus-based CPU datapath.
- Replaces hand-stepped T0..Tn control with an FSM that fetches, decodes the IR opcode and emits the datapath strobes for each instruction class.
- Compared with a fixed single-instruction sequence, it adds a memory ready handshake, conditional branching, run/halt control and configurable opcode width.
- Sits between the IR/CON flip-flop and every enable/out strobe of CPUproject.

Parameters:
OPCODE_W, 5, opcode field width (IR[31:32-OPCODE_W]); opcode values below are for width 5, zero-extended otherwise
MEM_HANDSHAKE, 1, 1 = memory steps wait for mem_ready; 0 = memory steps take exactly one cycle
STEP_W, 4, width of step output

Ports:
clk  in  1  rising-edge clock
clr  in  1  asynchronous active-low reset
run  in  1  level; 1 = execute, 0 = stop at next instruction boundary
opcode  in  OPCODE_W  IR opcode field, valid from T4
con_ff  in  1  branch condition flip-flop
mem_ready  in  1  memory read/write complete
PCout, MARin, IncPC, PCin  out  1 each  PC/MAR strobes
Read, Write, MDRin, MDRout, IRin  out  1 each  memory/IR strobes
Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register-select strobes
Yin, Cout, ZLowIn, ZHighIn, ZLowout, CONin  out  1 each  ALU/CON strobes
step  out  STEP_W  current T-step index (IDLE=0, HALT=all ones)
halted  out  1  high in HALT
illegal  out  1  one-cycle pulse on undefined opcode

Behaviour:
- State is registered. Strobes are a Moore decode of state plus latched class, except the T7 branch PCin/ZLowout, which also depend on con_ff.
- clr low, at any time, forces IDLE. All strobes, halted and illegal read 0 and step reads 0 within the same cycle.
- IDLE: move to T0 when run=1.
- T1: if run=0 sampled at T0, go to IDLE after the current instruction's final step.
- Fetch, common to all instructions:
  - T0: PCout, MARin, IncPC, ZLowIn.
  - T1: ZLowout, PCin.
  - T2: Read, MDRin. Held while MEM_HANDSHAKE=1 and mem_ready=0; advance on the cycle mem_ready=1.
  - T3: MDRout, IRin.
- Decode at T3->T4: opcode class is latched. Classes:
  - ld = 0, st = 2: memory.
  - 3..11: ALU reg-reg.
  - 12..14: ALU immediate (andi = 12).
  - 18: branch.
  - 26: nop.
  - 27: halt.
  - Anything else: illegal. Pulse illegal, treat as nop.
- ALU reg-reg:
  - T4: Grb, Rout, Yin.
  - T5: Grc, Rout, ZLowIn, ZHighIn.
  - T6: ZLowout, Gra, Rin. Then T0.
- ALU immediate: same as reg-reg except T5 is Cout, ZLowIn, ZHighIn.
- ld:
  - T4: Grb, BAout, Yin.
  - T5: Cout, ZLowIn.
  - T6: ZLowout, MARin.
  - T7: Read, MDRin. Waits on mem_ready as in T2.
  - T8: MDRout, Gra, Rin.
- st:
  - T4-T6: as ld.
  - T7: Gra, Rout, MDRin.
  - T8: Write. Waits on mem_ready.
- branch:
  - T4: Gra, Rout, CONin.
  - T5: PCout, Yin.
  - T6: Cout, ZLowIn.
  - T7: ZLowout and PCin only if con_ff=1. T7 always occupies one cycle.
- nop/illegal: T4 only, no strobes, then T0.
- halt: T4 goes to HALT. HALT holds regardless of run; only clr exits.
- Timing: every non-wait step is exactly one cycle. Instruction lengths with no wait cycles:
  - ALU: 7 cycles.
  - ld/st: 9 cycles.
  - branch: 8 cycles.
  - nop: 5 cycles.
- Mutual exclusion: never more than one of PCout, MDRout, Rout, ZLowout, Cout, BAout may be high in any cycle.
- mem_ready high outside a wait step is ignored.
- run toggling mid-instruction never truncates the instruction.

Test Plan:
- Reset: clr=0 mid-T5 of an ALU op -> all strobes 0 and step=0 immediately. After clr=1 and run=1 -> T0 on the next edge.
- andi: opcode 12, MEM_HANDSHAKE=0, run=1 -> steps 0,1,2,3,4,5,6 then 0. T5 shows Cout=ZLowIn=ZHighIn=1. T6 shows ZLowout=Gra=Rin=1. 7 cycles total.
- Fetch wait: mem_ready held 0 for 3 cycles in T2 -> Read=MDRin=1 for 4 cycles, then T3 with MDRout=IRin=1.
- Branch: opcode 18 with con_ff=0 -> T7 has PCin=0. Repeat with con_ff=1 -> T7 has PCin=ZLowout=1.
- Halt/illegal: opcode 30 -> illegal pulses one cycle at T4, then T0. Opcode 27 -> halted=1 and step=15, held for 20 cycles with run=1.
- Stop: run dropped during T4 of a ld -> ld completes through T8, then IDLE. No further PCout.

Source files
------------

// File: rtl/ctrl_sequencer.sv
// Hardwired control sequencer for the bus-based CPU datapath: fetch, decode and
// per-class execute steps with memory handshake, branch condition and run/halt control.
module ctrl_sequencer #(
   parameter int OPCODE_W      = 5,
   parameter int MEM_HANDSHAKE = 1,
   parameter int STEP_W        = 4
) (
   input  logic                clk,
   input  logic                clr,
   input  logic                run,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                con_ff,
   input  logic                mem_ready,
   output logic                PCout,
   output logic                MARin,
   output logic                IncPC,
   output logic                PCin,
   output logic                Read,
   output logic                Write,
   output logic                MDRin,
   output logic                MDRout,
   output logic                IRin,
   output logic                Gra,
   output logic                Grb,
   output logic                Grc,
   output logic                Rin,
   output logic                Rout,
   output logic                BAout,
   output logic                Yin,
   output logic                Cout,
   output logic                ZLowIn,
   output logic                ZHighIn,
   output logic                ZLowout,
   output logic                CONin,
   output logic [STEP_W-1:0]   step,
   output logic                halted,
   output logic                illegal
);

   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_T0   = 4'd1,
      S_T1   = 4'd2,
      S_T2   = 4'd3,
      S_T3   = 4'd4,
      S_T4   = 4'd5,
      S_T5   = 4'd6,
      S_T6   = 4'd7,
      S_T7   = 4'd8,
      S_T8   = 4'd9,
      S_HALT = 4'd10
   } state_t;

   typedef enum logic [2:0] {
      C_LD   = 3'd0,
      C_ST   = 3'd1,
      C_ALU  = 3'd2,
      C_IMM  = 3'd3,
      C_BR   = 3'd4,
      C_NOP  = 3'd5,
      C_HALT = 3'd6,
      C_ILL  = 3'd7
   } cls_t;

   typedef struct packed {
      logic pc_out;
      logic mar_in;
      logic inc_pc;
      logic pc_in;
      logic read;
      logic write;
      logic mdr_in;
      logic mdr_out;
      logic ir_in;
      logic gra;
      logic grb;
      logic grc;
      logic r_in;
      logic r_out;
      logic ba_out;
      logic y_in;
      logic c_out;
      logic zlow_in;
      logic zhigh_in;
      logic zlow_out;
      logic con_in;
      logic illegal;
      logic halted;
      logic br_t7;
   } strobe_t;

   function automatic cls_t classify(input logic [OPCODE_W-1:0] op);
      logic [31:0] v;
      cls_t        c;
      v = 32'(op);
      if (v == 32'd0) begin
         c = C_LD;
      end else if (v == 32'd2) begin
         c = C_ST;
      end else if (v >= 32'd3 && v <= 32'd11) begin
         c = C_ALU;
      end else if (v >= 32'd12 && v <= 32'd14) begin
         c = C_IMM;
      end else if (v == 32'd18) begin
         c = C_BR;
      end else if (v == 32'd26) begin
         c = C_NOP;
      end else if (v == 32'd27) begin
         c = C_HALT;
      end else begin
         c = C_ILL;
      end
      return c;
   endfunction

   function automatic logic [STEP_W-1:0] step_of(input state_t s);
      logic [STEP_W-1:0] r;
      case (s)
         S_T0:    r = STEP_W'(4'd0);
         S_T1:    r = STEP_W'(4'd1);
         S_T2:    r = STEP_W'(4'd2);
         S_T3:    r = STEP_W'(4'd3);
         S_T4:    r = STEP_W'(4'd4);
         S_T5:    r = STEP_W'(4'd5);
         S_T6:    r = STEP_W'(4'd6);
         S_T7:    r = STEP_W'(4'd7);
         S_T8:    r = STEP_W'(4'd8);
         S_HALT:  r = {STEP_W{1'b1}};
         default: r = {STEP_W{1'b0}};
      endcase
      return r;
   endfunction

   // Moore strobe decode; the branch T7 PC load is only flagged here and gated by con_ff later.
   function automatic strobe_t decode(input state_t s, input cls_t c);
      strobe_t d;
      d = '0;
      case (s)
         S_T0: begin
            d.pc_out  = 1'b1;
            d.mar_in  = 1'b1;
            d.inc_pc  = 1'b1;
            d.zlow_in = 1'b1;
         end
         S_T1: begin
            d.zlow_out = 1'b1;
            d.pc_in    = 1'b1;
         end
         S_T2: begin
            d.read   = 1'b1;
            d.mdr_in = 1'b1;
         end
         S_T3: begin
            d.mdr_out = 1'b1;
            d.ir_in   = 1'b1;
         end
         S_T4: begin
            case (c)
               C_LD, C_ST: begin
                  d.grb    = 1'b1;
                  d.ba_out = 1'b1;
                  d.y_in   = 1'b1;
               end
               C_ALU, C_IMM: begin
                  d.grb   = 1'b1;
                  d.r_out = 1'b1;
                  d.y_in  = 1'b1;
               end
               C_BR: begin
                  d.gra    = 1'b1;
                  d.r_out  = 1'b1;
                  d.con_in = 1'b1;
               end
               C_ILL:   d.illegal = 1'b1;
               default: d = '0;
            endcase
         end
         S_T5: begin
            case (c)
               C_LD, C_ST: begin
                  d.c_out   = 1'b1;
                  d.zlow_in = 1'b1;
               end
               C_ALU: begin
                  d.grc      = 1'b1;
                  d.r_out    = 1'b1;
                  d.zlow_in  = 1'b1;
                  d.zhigh_in = 1'b1;
               end
               C_IMM: begin
                  d.c_out    = 1'b1;
                  d.zlow_in  = 1'b1;
                  d.zhigh_in = 1'b1;
               end
               C_BR: begin
                  d.pc_out = 1'b1;
                  d.y_in   = 1'b1;
               end
               default: d = '0;
            endcase
         end
         S_T6: begin
            case (c)
               C_LD, C_ST: begin
                  d.zlow_out = 1'b1;
                  d.mar_in   = 1'b1;
               end
               C_ALU, C_IMM: begin
                  d.zlow_out = 1'b1;
                  d.gra      = 1'b1;
                  d.r_in     = 1'b1;
               end
               C_BR: begin
                  d.c_out   = 1'b1;
                  d.zlow_in = 1'b1;
               end
               default: d = '0;
            endcase
         end
         S_T7: begin
            case (c)
               C_LD: begin
                  d.read   = 1'b1;
                  d.mdr_in = 1'b1;
               end
               C_ST: begin
                  d.gra    = 1'b1;
                  d.r_out  = 1'b1;
                  d.mdr_in = 1'b1;
               end
               C_BR:    d.br_t7 = 1'b1;
               default: d = '0;
            endcase
         end
         S_T8: begin
            case (c)
               C_LD: begin
                  d.mdr_out = 1'b1;
                  d.gra     = 1'b1;
                  d.r_in    = 1'b1;
               end
               C_ST:    d.write = 1'b1;
               default: d = '0;
            endcase
         end
         S_HALT:  d.halted = 1'b1;
         default: d = '0;
      endcase
      return d;
   endfunction

   state_t            state_r;
   state_t            state_nx;
   cls_t              cls_r;
   cls_t              cls_nx;
   logic              stop_r;
   logic              stop_nx;
   strobe_t           strb_r;
   logic [STEP_W-1:0] step_r;
   state_t            fin_s;
   logic              hold_s;

   // An instruction ends in IDLE if run was low at its T0 or is low at its final step.
   assign fin_s  = (stop_r || !run) ? S_IDLE : S_T0;
   assign hold_s = (MEM_HANDSHAKE != 0) && !mem_ready;

   // Next-state, class latch and stop-request logic.
   always_comb begin
      state_nx = state_r;
      cls_nx   = cls_r;
      stop_nx  = stop_r;
      case (state_r)
         S_IDLE: begin
            if (run) begin
               state_nx = S_T0;
            end else begin
               state_nx = S_IDLE;
            end
         end
         S_T0: begin
            state_nx = S_T1;
            stop_nx  = !run;
         end
         S_T1: state_nx = S_T2;
         S_T2: begin
            if (hold_s) begin
               state_nx = S_T2;
            end else begin
               state_nx = S_T3;
            end
         end
         S_T3: begin
            state_nx = S_T4;
            cls_nx   = classify(opcode);
         end
         S_T4: begin
            case (cls_r)
               C_HALT:       state_nx = S_HALT;
               C_NOP, C_ILL: state_nx = fin_s;
               default:      state_nx = S_T5;
            endcase
         end
         S_T5: state_nx = S_T6;
         S_T6: begin
            if (cls_r == C_ALU || cls_r == C_IMM) begin
               state_nx = fin_s;
            end else begin
               state_nx = S_T7;
            end
         end
         S_T7: begin
            case (cls_r)
               C_LD:    state_nx = hold_s ? S_T7 : S_T8;
               C_ST:    state_nx = S_T8;
               default: state_nx = fin_s;
            endcase
         end
         S_T8: begin
            if (cls_r == C_ST && hold_s) begin
               state_nx = S_T8;
            end else begin
               state_nx = fin_s;
            end
         end
         S_HALT:  state_nx = S_HALT;
         default: state_nx = S_IDLE;
      endcase
   end

   // State and registered strobes, all cleared asynchronously by clr.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_r <= S_IDLE;
         cls_r   <= C_NOP;
         stop_r  <= 1'b0;
         strb_r  <= '0;
         step_r  <= {STEP_W{1'b0}};
      end else begin
         state_r <= state_nx;
         cls_r   <= cls_nx;
         stop_r  <= stop_nx;
         strb_r  <= decode(state_nx, cls_nx);
         step_r  <= step_of(state_nx);
      end
   end

   assign PCout   = strb_r.pc_out;
   assign MARin   = strb_r.mar_in;
   assign IncPC   = strb_r.inc_pc;
   assign PCin    = strb_r.pc_in | (strb_r.br_t7 & con_ff);
   assign Read    = strb_r.read;
   assign Write   = strb_r.write;
   assign MDRin   = strb_r.mdr_in;
   assign MDRout  = strb_r.mdr_out;
   assign IRin    = strb_r.ir_in;
   assign Gra     = strb_r.gra;
   assign Grb     = strb_r.grb;
   assign Grc     = strb_r.grc;
   assign Rin     = strb_r.r_in;
   assign Rout    = strb_r.r_out;
   assign BAout   = strb_r.ba_out;
   assign Yin     = strb_r.y_in;
   assign Cout    = strb_r.c_out;
   assign ZLowIn  = strb_r.zlow_in;
   assign ZHighIn = strb_r.zhigh_in;
   assign ZLowout = strb_r.zlow_out | (strb_r.br_t7 & con_ff);
   assign CONin   = strb_r.con_in;
   assign step    = step_r;
   assign halted  = strb_r.halted;
   assign illegal = strb_r.illegal;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: directed table, multi-cycle corner sequences and
// randomized instruction streams checked against a per-instruction step-plan model.
module tb_ctrl_sequencer;

   logic       clk = 1'b0;
   logic       clr, run, con_ff, mem_ready;
   logic [4:0] opcode;
   logic       PCout, MARin, IncPC, PCin, Read, Write, MDRin, MDRout, IRin;
   logic       Gra, Grb, Grc, Rin, Rout, BAout, Yin, Cout, ZLowIn, ZHighIn, ZLowout, CONin;
   logic [3:0] step;
   logic       halted, illegal;
   logic [22:0] obs;

   always #5 clk = ~clk;

   ctrl_sequencer dut (
      .clk(clk), .clr(clr), .run(run), .opcode(opcode), .con_ff(con_ff), .mem_ready(mem_ready),
      .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin),
      .Read(Read), .Write(Write), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
      .Yin(Yin), .Cout(Cout), .ZLowIn(ZLowIn), .ZHighIn(ZHighIn), .ZLowout(ZLowout), .CONin(CONin),
      .step(step), .halted(halted), .illegal(illegal)
   );

   assign obs = {halted, illegal, CONin, ZLowout, ZHighIn, ZLowIn, Cout, Yin, BAout, Rout, Rin,
                 Grc, Grb, Gra, IRin, MDRout, MDRin, Write, Read, PCin, IncPC, MARin, PCout};

   localparam logic [22:0] K_PCOUT  = 23'd1 << 0;
   localparam logic [22:0] K_MARIN  = 23'd1 << 1;
   localparam logic [22:0] K_INCPC  = 23'd1 << 2;
   localparam logic [22:0] K_PCIN   = 23'd1 << 3;
   localparam logic [22:0] K_READ   = 23'd1 << 4;
   localparam logic [22:0] K_WRITE  = 23'd1 << 5;
   localparam logic [22:0] K_MDRIN  = 23'd1 << 6;
   localparam logic [22:0] K_MDROUT = 23'd1 << 7;
   localparam logic [22:0] K_IRIN   = 23'd1 << 8;
   localparam logic [22:0] K_GRA    = 23'd1 << 9;
   localparam logic [22:0] K_GRB    = 23'd1 << 10;
   localparam logic [22:0] K_GRC    = 23'd1 << 11;
   localparam logic [22:0] K_RIN    = 23'd1 << 12;
   localparam logic [22:0] K_ROUT   = 23'd1 << 13;
   localparam logic [22:0] K_BAOUT  = 23'd1 << 14;
   localparam logic [22:0] K_YIN    = 23'd1 << 15;
   localparam logic [22:0] K_COUT   = 23'd1 << 16;
   localparam logic [22:0] K_ZLOWIN = 23'd1 << 17;
   localparam logic [22:0] K_ZHIGHIN = 23'd1 << 18;
   localparam logic [22:0] K_ZLOWOUT = 23'd1 << 19;
   localparam logic [22:0] K_CONIN  = 23'd1 << 20;
   localparam logic [22:0] K_ILLEGAL = 23'd1 << 21;
   localparam logic [22:0] K_HALTED = 23'd1 << 22;

   localparam logic [22:0] M_T0 = K_PCOUT | K_MARIN | K_INCPC | K_ZLOWIN;
   localparam logic [22:0] M_T1 = K_ZLOWOUT | K_PCIN;
   localparam logic [22:0] M_T2 = K_READ | K_MDRIN;
   localparam logic [22:0] M_T3 = K_MDROUT | K_IRIN;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic [4:0]  op;
      logic        con;
      int          exp_step;
      logic [22:0] exp_mask;
   } vec_t;

   // Step plan of one instruction: step index, expected strobes, whether it waits on mem_ready.
   int          pstep[16];
   logic [22:0] pmask[16];
   bit          pwait[16];
   int          pn;

   task automatic chk(input string name, input int es, input logic [22:0] em);
      vectors++;
      if (step !== 4'(es) || obs !== em) begin
         miscompares++;
         $display("FAIL %s: got step=%0d strobes=%06h, want step=%0d strobes=%06h",
                  name, step, obs, es, em);
      end
   endtask

   function automatic void push(input int s, input logic [22:0] m, input bit w);
      pstep[pn] = s;
      pmask[pn] = m;
      pwait[pn] = w;
      pn++;
   endfunction

   function automatic void plan(input int op, input bit con);
      pn = 0;
      push(0, M_T0, 1'b0);
      push(1, M_T1, 1'b0);
      push(2, M_T2, 1'b1);
      push(3, M_T3, 1'b0);
      if (op == 0 || op == 2) begin
         push(4, K_GRB | K_BAOUT | K_YIN, 1'b0);
         push(5, K_COUT | K_ZLOWIN, 1'b0);
         push(6, K_ZLOWOUT | K_MARIN, 1'b0);
         if (op == 0) begin
            push(7, K_READ | K_MDRIN, 1'b1);
            push(8, K_MDROUT | K_GRA | K_RIN, 1'b0);
         end else begin
            push(7, K_GRA | K_ROUT | K_MDRIN, 1'b0);
            push(8, K_WRITE, 1'b1);
         end
      end else if (op >= 3 && op <= 14) begin
         push(4, K_GRB | K_ROUT | K_YIN, 1'b0);
         if (op <= 11) push(5, K_GRC | K_ROUT | K_ZLOWIN | K_ZHIGHIN, 1'b0);
         else          push(5, K_COUT | K_ZLOWIN | K_ZHIGHIN, 1'b0);
         push(6, K_ZLOWOUT | K_GRA | K_RIN, 1'b0);
      end else if (op == 18) begin
         push(4, K_GRA | K_ROUT | K_CONIN, 1'b0);
         push(5, K_PCOUT | K_YIN, 1'b0);
         push(6, K_COUT | K_ZLOWIN, 1'b0);
         push(7, con ? (K_ZLOWOUT | K_PCIN) : 23'd0, 1'b0);
      end else if (op == 26 || op == 27) begin
         push(4, 23'd0, 1'b0);
      end else begin
         push(4, K_ILLEGAL, 1'b0);
      end
   endfunction

   // mode 0: mem_ready always 1; 1: random mem_ready and run; 2: 3-cycle hold on each wait step.
   task automatic exec(input int op, input bit con, input int mode, input int drop_at,
                       output bit to_idle);
      bit stop;
      bit mr;
      int c;
      plan(op, con);
      opcode = 5'(op);
      con_ff = con;
      stop   = 1'b0;
      for (int i = 0; i < pn; i++) begin
         c = 0;
         forever begin
            @(negedge clk);
            chk($sformatf("op%0d_T%0d_c%0d", op, pstep[i], c), pstep[i], pmask[i]);
            if (mode == 1)      mr = (c >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
            else if (mode == 2) mr = (c >= 3);
            else                mr = 1'b1;
            mem_ready = mr;
            if (mode == 1) run = ($urandom_range(0, 7) != 0);
            if (i == drop_at) run = 1'b0;
            if (i == 0) stop = !run;
            if (!(pwait[i] && !mr)) break;
            c++;
         end
      end
      to_idle = stop || !run;
   endtask

   vec_t tbl[23];

   initial begin
      bit idle;
      int op;
      int r;

      tbl = '{
         '{5'd12, 1'b0, 0, M_T0}, '{5'd12, 1'b0, 1, M_T1}, '{5'd12, 1'b0, 2, M_T2},
         '{5'd12, 1'b0, 3, M_T3}, '{5'd12, 1'b0, 4, K_GRB | K_ROUT | K_YIN},
         '{5'd12, 1'b0, 5, K_COUT | K_ZLOWIN | K_ZHIGHIN},
         '{5'd12, 1'b0, 6, K_ZLOWOUT | K_GRA | K_RIN},
         '{5'd18, 1'b0, 0, M_T0}, '{5'd18, 1'b0, 1, M_T1}, '{5'd18, 1'b0, 2, M_T2},
         '{5'd18, 1'b0, 3, M_T3}, '{5'd18, 1'b0, 4, K_GRA | K_ROUT | K_CONIN},
         '{5'd18, 1'b0, 5, K_PCOUT | K_YIN}, '{5'd18, 1'b0, 6, K_COUT | K_ZLOWIN},
         '{5'd18, 1'b0, 7, 23'd0},
         '{5'd18, 1'b1, 0, M_T0}, '{5'd18, 1'b1, 1, M_T1}, '{5'd18, 1'b1, 2, M_T2},
         '{5'd18, 1'b1, 3, M_T3}, '{5'd18, 1'b1, 4, K_GRA | K_ROUT | K_CONIN},
         '{5'd18, 1'b1, 5, K_PCOUT | K_YIN}, '{5'd18, 1'b1, 6, K_COUT | K_ZLOWIN},
         '{5'd18, 1'b1, 7, K_ZLOWOUT | K_PCIN}
      };

      clr = 1'b0; run = 1'b0; con_ff = 1'b0; mem_ready = 1'b0; opcode = 5'd0;
      repeat (3) @(negedge clk);
      chk("reset", 0, 23'd0);
      clr = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("idle_run0", 0, 23'd0);
      end
      run = 1'b1;

      for (int i = 0; i < 23; i++) begin
         opcode    = tbl[i].op;
         con_ff    = tbl[i].con;
         mem_ready = 1'b1;
         run       = 1'b1;
         @(negedge clk);
         chk($sformatf("tbl%0d", i), tbl[i].exp_step, tbl[i].exp_mask);
      end

      exec(26, 1'b0, 2, -1, idle);
      exec(30, 1'b0, 0, -1, idle);

      plan(5, 1'b0);
      opcode = 5'd5; mem_ready = 1'b1; run = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk($sformatf("pre_clr_T%0d", pstep[i]), pstep[i], pmask[i]);
      end
      clr = 1'b0;
      #1;
      chk("clr_mid_T5", 0, 23'd0);
      @(negedge clk);
      clr = 1'b1;
      run = 1'b1;
      exec(12, 1'b0, 0, -1, idle);

      for (int n = 0; n < 80; n++) begin
         r = $urandom_range(0, 9);
         case (r)
            0:       op = 0;
            1:       op = 2;
            2:       op = $urandom_range(3, 11);
            3:       op = $urandom_range(12, 14);
            4, 5:    op = 18;
            6:       op = 26;
            7:       op = $urandom_range(19, 25);
            8:       op = ($urandom_range(0, 1) != 0) ? $urandom_range(28, 31) : $urandom_range(15, 17);
            default: op = 1;
         endcase
         exec(op, 1'($urandom_range(0, 1)), 1, -1, idle);
         if (idle) begin
            @(negedge clk);
            chk("rand_idle", 0, 23'd0);
         end
         run = 1'b1;
      end

      exec(0, 1'b0, 0, 4, idle);
      repeat (3) begin
         @(negedge clk);
         chk("stop_idle", 0, 23'd0);
      end
      run = 1'b1;

      exec(27, 1'b0, 0, -1, idle);
      repeat (20) begin
         @(negedge clk);
         chk("halt_hold", 15, K_HALTED);
      end
      clr = 1'b0;
      #1;
      chk("clr_exit_halt", 0, 23'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
